// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the program loader: the loader FSM state encoding and
// the stream-format constants (bytes per imem word, length-prefix bytes).
// No ports; imported by imem_loader and byte_packer.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles BYTES_PER_WORD little-endian bytes into one imem word. The first
// byte shifted in after a clear lands in bits [7:0].
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-low reset (clears index and word)
//   clear      restart assembly at byte 0
//   shift      a byte is being accepted this cycle
//   byte_in    the byte being accepted
//   word       assembled word (registered)
//   word_full  high in the cycle the last byte of a word is being accepted
// -----------------------------------------------------------------------------
module byte_packer
   import imem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = BYTES_PER_WORD * 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  shift,
   input  logic [7:0]            byte_in,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_full
);

   localparam int                IDX_W    = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [IDX_W-1:0] byte_idx;

   // Combinational so the FSM can leave DATA on the same edge that stores the
   // last byte, giving the 4-bytes-per-5-cycles peak rate.
   assign word_full = shift && (byte_idx == LAST_IDX);

   always_ff @(posedge clock) begin
      if (!reset) begin
         byte_idx <= '0;
         word     <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (shift) begin
         word[{byte_idx, 3'b000} +: 8] <= byte_in;
         // Index wraps back to 0 after the last byte, ready for the next word.
         byte_idx <= byte_idx + 1'b1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program image into instruction memory from a byte stream while
// holding the processor in reset; releases the processor once the whole image
// has been written. Stream: 16-bit little-endian word count N, then 4*N bytes,
// each word little-endian.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-low reset
//   start       one-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_valid    byte-stream valid
//   in_data     byte-stream data
//   in_ready    loader accepts a byte this cycle
//   imem_addr   imem write address
//   imem_data   imem write data
//   imem_wren   imem write strobe, one cycle per word
//   proc_reset  active-high processor hold
//   busy        load in progress
//   done        image written, processor released
//   error       word count exceeds the imem space above BASE_ADDR
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_data,
   output logic                  imem_wren,
   output logic                  proc_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
   // Number of words that fit between BASE_ADDR and the top of imem.
   localparam logic [32:0]           MAX_WORDS = 33'((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR));

   state_t      state;
   logic [7:0]  len_lo;
   logic [15:0] remaining;
   logic [15:0] len_word;
   logic        accept;
   logic        data_shift;
   logic        pack_clear;
   logic        word_full;

   assign accept     = in_valid && in_ready;
   assign data_shift = accept && (state == DATA);
   assign len_word   = {in_data, len_lo};
   assign pack_clear = start && ((state == IDLE) || (state == DONE) || (state == ERR));

   // imem_data is the packer's word register: it holds the assembled word
   // through the WRITE cycle because no byte is accepted while in_ready=0.
   byte_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_byte_packer (
      .clock     (clock),
      .reset     (reset),
      .clear     (pack_clear),
      .shift     (data_shift),
      .byte_in   (in_data),
      .word      (imem_data),
      .word_full (word_full)
   );

   // All outputs are registered and updated together with the state, so each
   // one is a clean function of the state being entered.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         proc_reset <= 1'b1;
         in_ready   <= 1'b0;
         imem_wren  <= 1'b0;
         imem_addr  <= BASE;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         len_lo     <= '0;
         remaining  <= '0;
      end else begin
         imem_wren <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LEN_LO;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LEN_LO: begin
               if (accept) begin
                  len_lo <= in_data;
                  state  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (accept) begin
                  if (len_word == 16'd0) begin
                     state      <= DONE;
                     in_ready   <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     proc_reset <= 1'b0;
                  end else if ({17'd0, len_word} > MAX_WORDS) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state     <= DATA;
                     remaining <= len_word;
                  end
               end
            end
            DATA: begin
               if (word_full) begin
                  state     <= WRITE;
                  in_ready  <= 1'b0;
                  imem_wren <= 1'b1;
               end
            end
            WRITE: begin
               remaining <= remaining - 16'd1;
               if (remaining == 16'd1) begin
                  // Address is not advanced past the final word, so a full
                  // image ending at the top of imem never wraps to 0.
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  proc_reset <= 1'b0;
               end else begin
                  imem_addr <= imem_addr + 1'b1;
                  state     <= DATA;
                  in_ready  <= 1'b1;
               end
            end
            DONE, ERR: begin
               if (start) begin
                  state      <= LEN_LO;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  proc_reset <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  imem_addr  <= BASE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
